// File: rtl/imm_ext_stage.sv
// Registered immediate-extension stage: zero/sign/high/ones/branch-offset.
// Define EXT_SKID_EN to add a one-entry skid register and a flopped in_ready.
module imm_ext_stage #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [2:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam int UP_W = OUT_W - IN_W;

  typedef enum logic [2:0] {
    M_ZERO = 3'd0,
    M_SIGN = 3'd1,
    M_HIGH = 3'd2,
    M_ONES = 3'd3,
    M_BOFS = 3'd4
  } mode_e;

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] ext_imm;
  logic             ext_ill;

  always_comb begin
    sext    = {{UP_W{in_imm[IN_W-1]}}, in_imm};
    ext_imm = '0;
    ext_ill = 1'b0;
    unique case (in_mode)
      M_ZERO:  ext_imm = {{UP_W{1'b0}}, in_imm};
      M_SIGN:  ext_imm = sext;
      M_HIGH:  ext_imm = {in_imm, {UP_W{1'b0}}};
      M_ONES:  ext_imm = {{UP_W{1'b1}}, in_imm};
      M_BOFS:  ext_imm = sext << 2;
      default: ext_ill = 1'b1;
    endcase
  end

  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_imm_q, out_imm_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             out_ill_q, out_ill_d;
  logic             in_fire;

  assign out_valid   = out_valid_q;
  assign out_imm     = out_imm_q;
  assign out_tag     = out_tag_q;
  assign out_illegal = out_ill_q;

`ifdef EXT_SKID_EN

  logic             skid_valid_q, skid_valid_d;
  logic [OUT_W-1:0] skid_imm_q, skid_imm_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
  logic             skid_ill_q, skid_ill_d;
  logic             in_ready_q, in_ready_d;

  assign in_ready = in_ready_q;
  assign in_fire  = in_valid && in_ready_q;

  // in_ready tracks !skid_valid, so a fire never meets a full skid.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_tag_d    = out_tag_q;
    out_ill_d    = out_ill_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_tag_d   = skid_tag_q;
    skid_ill_d   = skid_ill_q;
    if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_imm_d    = skid_imm_q;
        out_tag_d    = skid_tag_q;
        out_ill_d    = skid_ill_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_valid_d = 1'b1;
        out_imm_d   = ext_imm;
        out_tag_d   = in_tag;
        out_ill_d   = ext_ill;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = ext_imm;
      skid_tag_d   = in_tag;
      skid_ill_d   = ext_ill;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_tag_q   <= '0;
      skid_ill_q   <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_tag_q   <= skid_tag_d;
      skid_ill_q   <= skid_ill_d;
      in_ready_q   <= in_ready_d;
    end
  end

`else

  logic alive_q;

  assign in_ready = alive_q && (!out_valid_q || out_ready);
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_imm_d   = out_imm_q;
    out_tag_d   = out_tag_q;
    out_ill_d   = out_ill_q;
    if (in_fire) begin
      out_valid_d = 1'b1;
      out_imm_d   = ext_imm;
      out_tag_d   = in_tag;
      out_ill_d   = ext_ill;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Holds in_ready low until the first edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alive_q <= 1'b0;
    end else begin
      alive_q <= 1'b1;
    end
  end

`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_imm_q   <= '0;
      out_tag_q   <= '0;
      out_ill_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_imm_q   <= out_imm_d;
      out_tag_q   <= out_tag_d;
      out_ill_q   <= out_ill_d;
    end
  end

endmodule

// File: tb/tb_imm_ext_stage.sv
// Scoreboard bench for imm_ext_stage: directed beats, stall, reset, random.
// Second instance covers IN_W=12 / OUT_W=20.
module tb_imm_ext_stage;

  localparam int IN_W  = 16;
  localparam int OUT_W = 32;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [2:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  logic        in_valid2;
  logic        in_ready2;
  logic [11:0] in_imm2;
  logic [2:0]  in_mode2;
  logic [4:0]  in_tag2;
  logic        out_valid2;
  logic        out_ready2;
  logic [19:0] out_imm2;
  logic [4:0]  out_tag2;
  logic        out_illegal2;

  always #5 clk = ~clk;

  imm_ext_stage #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_imm(in_imm), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_tag(out_tag), .out_illegal(out_illegal)
  );

  imm_ext_stage #(.IN_W(12), .OUT_W(20), .TAG_W(5)) u_dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .in_imm(in_imm2), .in_mode(in_mode2), .in_tag(in_tag2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_imm(out_imm2), .out_tag(out_tag2), .out_illegal(out_illegal2)
  );

  typedef struct packed {
    logic [OUT_W-1:0] imm;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } exp_t;

  exp_t sb[$];
  int   errs = 0;
  int   checks = 0;
  bit   rdy_force = 1'b1;
  bit   rdy_val = 1'b1;
  int   falls = 0;

  // Reference: extension rules as signed integer arithmetic mod 2**ow.
  function automatic longint ref_ext(input int iw, input int ow,
                                     input longint imm, input int mode,
                                     output bit ill);
    longint s, r, mo, mi;
    mo  = longint'(1) << ow;
    mi  = longint'(1) << iw;
    s   = (imm >= (mi / 2)) ? imm - mi : imm;
    ill = 1'b0;
    case (mode)
      0: r = imm;
      1: r = s;
      2: r = imm * (longint'(1) << (ow - iw));
      3: r = imm + mo - mi;
      4: r = s * 4;
      default: begin r = 0; ill = 1'b1; end
    endcase
    return r & (mo - 1);
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int k);
    in_valid = 1'b0;
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [15:0] imm, input logic [2:0] mode,
                      input logic [4:0] tag);
    exp_t e;
    bit   ill;
    bit   acc;
    int   n;
    e.imm = OUT_W'(ref_ext(IN_W, OUT_W, longint'(imm), int'(mode), ill));
    e.tag = tag;
    e.ill = ill;
    in_valid = 1'b1;
    in_imm   = imm;
    in_mode  = mode;
    in_tag   = tag;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
      end else begin
        n++;
        @(posedge clk);
        #1;
      end
    end
    if (acc) begin
      sb.push_back(e);
      @(posedge clk);
      #1;
    end else begin
      checks++;
      errs++;
      $display("FAIL accept_timeout: tag %0d never accepted", tag);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    bit prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (prev && !in_ready) falls++;
      prev = in_ready;
    end
  end

  // Monitor: pops on every output transfer, checks hold during stalls.
  initial begin
    exp_t e;
    exp_t snap;
    exp_t act;
    bit   have;
    have = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !out_valid) begin
        have = 1'b0;
      end else begin
        act = '{out_imm, out_tag, out_illegal};
        if (have) begin
          checks++;
          if (act !== snap) begin
            errs++;
            $display("FAIL stall_hold: got %h expected %h", act, snap);
          end
        end
        if (out_ready) begin
          have = 1'b0;
          checks++;
          if (sb.size() == 0) begin
            errs++;
            $display("FAIL extra_beat: got imm=%h tag=%0d with nothing expected",
                     out_imm, out_tag);
          end else begin
            e = sb.pop_front();
            if (act !== e) begin
              errs++;
              $display("FAIL beat: got imm=%h tag=%0d ill=%b expected imm=%h tag=%0d ill=%b",
                       out_imm, out_tag, out_illegal, e.imm, e.tag, e.ill);
            end
          end
        end else begin
          snap = act;
          have = 1'b1;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ill;
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    in_imm = '0;
    in_mode = '0;
    in_tag = '0;
    in_valid2 = 1'b0;
    in_imm2 = '0;
    in_mode2 = '0;
    in_tag2 = '0;
    out_ready2 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_imm", 64'(out_imm), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_out_illegal", 64'(out_illegal), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    send(16'h8000, 3'd0, 5'd3);
    send(16'h8000, 3'd1, 5'd4);
    send(16'h8000, 3'd3, 5'd5);
    send(16'h7FFF, 3'd3, 5'd6);
    send(16'h1234, 3'd2, 5'd8);
    send(16'hFFFF, 3'd4, 5'd9);
    send(16'h4000, 3'd4, 5'd10);
    send(16'hABCD, 3'd6, 5'd7);
    send(16'h0055, 3'd0, 5'd11);
    idle(3);

    falls = 0;
    fork
      begin
        send(16'h1111, 3'd0, 5'd1);
        send(16'h2222, 3'd1, 5'd2);
        send(16'h3333, 3'd3, 5'd3);
        send(16'hC444, 3'd4, 5'd4);
      end
      begin
        @(posedge clk);
        @(posedge clk);
        rdy_val = 1'b0;
        repeat (3) @(posedge clk);
        rdy_val = 1'b1;
      end
    join
    idle(3);
`ifdef EXT_SKID_EN
    check("skid_ready_falls", 64'(falls), 64'd1);
`endif

    rdy_val = 1'b0;
    send(16'h0042, 3'd0, 5'd9);
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_imm", 64'(out_imm), 64'd0);
    check("async_rst_tag", 64'(out_tag), 64'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    rdy_val = 1'b1;
    @(posedge clk);
    #1;
    send(16'h0001, 3'd1, 5'd2);
    check("post_rst_latency", 64'(out_valid), 64'd1);
    idle(3);

    rdy_force = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      send(16'($urandom), 3'($urandom_range(0, 7)), 5'($urandom));
    end
    rdy_force = 1'b1;
    rdy_val = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);

    @(posedge clk);
    #1;
    in_valid2 = 1'b1;
    in_imm2 = 12'h800;
    in_mode2 = 3'd1;
    in_tag2 = 5'd12;
    @(negedge clk);
    check("w12_ready", 64'(in_ready2), 64'd1);
    @(posedge clk);
    #1;
    in_imm2 = 12'hABC;
    in_mode2 = 3'd2;
    in_tag2 = 5'd13;
    check("w12_sign_valid", 64'(out_valid2), 64'd1);
    check("w12_sign_imm", 64'(out_imm2),
          64'(ref_ext(12, 20, 64'h800, 1, ill)));
    check("w12_sign_tag", 64'(out_tag2), 64'd12);
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    check("w12_high_imm", 64'(out_imm2),
          64'(ref_ext(12, 20, 64'hABC, 2, ill)));
    check("w12_high_ill", 64'(out_illegal2), 64'(ill));
    idle(2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
